// File: rtl/mp3_pc_debug_pkg.sv
// Shared definitions for the MP3_PC debug-host JTAG shift engine:
// state encoding, default widths, virtual IR codes and strobe decode.
package mp3_pc_debug_pkg;

    localparam int DBG_DR_WIDTH = 38;
    localparam int DBG_IR_WIDTH = 2;

    // Virtual IR codes understood by the Nios II debug slave
    localparam logic [DBG_IR_WIDTH-1:0] IR_OCIMEM    = 2'd0;
    localparam logic [DBG_IR_WIDTH-1:0] IR_TRACE     = 2'd1;
    localparam logic [DBG_IR_WIDTH-1:0] IR_BREAK     = 2'd2;
    localparam logic [DBG_IR_WIDTH-1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SHIFT,
        ST_UDR,
        ST_RTI,
        ST_RESP
    } dbg_state_t;

    // Virtual-state strobes for a state, packed as {uir, cdr, sdr, udr, rti}.
    // Idle and response states drive no strobe.
    function automatic logic [4:0] strobe_of(dbg_state_t s);
        logic [4:0] strb;
        strb = 5'b00000;
        case (s)
            ST_UIR:   strb = 5'b10000;
            ST_CDR:   strb = 5'b01000;
            ST_SHIFT: strb = 5'b00100;
            ST_UDR:   strb = 5'b00010;
            ST_RTI:   strb = 5'b00001;
            default:  strb = 5'b00000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mp3_pc_debug_jtag_host_if.sv
// Command/response bus between a debug client and the JTAG host engine.
// The client (master) issues IR+DR commands and collects captured DR/IR.
interface mp3_pc_debug_jtag_host_if
    import mp3_pc_debug_pkg::*;
#(
    parameter int DR_WIDTH = DBG_DR_WIDTH,
    parameter int IR_WIDTH = DBG_IR_WIDTH
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] rsp_ir;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir
    );
endinterface

// File: rtl/mp3_pc_debug_tck_gen.sv
// TCK divider: one TCK period is 2*TCK_DIV clk cycles, low half first.
// period_end marks the last clk cycle of each period; the engine advances
// on the edge that ends that cycle. When not running TCK parks low.
module mp3_pc_debug_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic vji_tck,
    output logic period_end
);
    localparam int P  = 2 * TCK_DIV;
    localparam int CW = (P > 2) ? $clog2(P) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Wrap detection and next divider count
    always_comb begin
        period_end = run && (cnt == CW'(P - 1));
        cnt_next   = (run && !period_end) ? cnt + CW'(1) : '0;
    end

    // Divider count and registered TCK level derived from the upcoming count
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            vji_tck <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            vji_tck <= (cnt_next >= CW'(TCK_DIV));
        end
    end

endmodule

// File: rtl/mp3_pc_debug_jtag_host.sv
// Debug-host shift engine driving the virtual-JTAG (vji_*) side of the
// Nios II debug slave: UIR -> CDR -> SDR x DR_WIDTH -> UDR -> RTI per command,
// returning the DR bits captured from vji_tdo and the IR read at end of UIR.
module mp3_pc_debug_jtag_host
    import mp3_pc_debug_pkg::*;
#(
    parameter int DR_WIDTH = DBG_DR_WIDTH,
    parameter int IR_WIDTH = DBG_IR_WIDTH,
    parameter int TCK_DIV  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mp3_pc_debug_jtag_host_if.slave host,
    output logic                 vji_tck,
    output logic                 vji_tdi,
    output logic [IR_WIDTH-1:0]  vji_ir_in,
    output logic                 vji_uir,
    output logic                 vji_cdr,
    output logic                 vji_sdr,
    output logic                 vji_udr,
    output logic                 vji_rti,
    input  logic                 vji_tdo,
    input  logic [IR_WIDTH-1:0]  vji_ir_out
);
    localparam int BCW = (DR_WIDTH > 2) ? $clog2(DR_WIDTH) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DR_WIDTH - 1);

    dbg_state_t          state;
    dbg_state_t          state_next;
    logic                accept;
    logic                period_end;
    logic                run;
    logic                last_bit;

    logic [DR_WIDTH-1:0] sr;
    logic [DR_WIDTH-1:0] shift_in;
    logic [BCW-1:0]      bit_cnt;
    logic [4:0]          strb;
    logic                tdi_q;
    logic [IR_WIDTH-1:0] ir_in_q;
    logic                rsp_valid_q;
    logic [DR_WIDTH-1:0] rsp_dr_q;
    logic [IR_WIDTH-1:0] rsp_ir_q;

    assign run      = (state != ST_IDLE) && (state != ST_RESP);
    assign last_bit = (bit_cnt == BIT_LAST);
    assign shift_in = {vji_tdo, sr[DR_WIDTH-1:1]};

    mp3_pc_debug_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .vji_tck    (vji_tck),
        .period_end (period_end)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; strobe states advance only at TCK period end
    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        host.cmd_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                host.cmd_ready = 1'b1;
                if (host.cmd_valid) begin
                    accept     = 1'b1;
                    state_next = ST_UIR;
                end
            end
            ST_UIR:   if (period_end) state_next = ST_CDR;
            ST_CDR:   if (period_end) state_next = ST_SHIFT;
            ST_SHIFT: if (period_end && last_bit) state_next = ST_UDR;
            ST_UDR:   if (period_end) state_next = ST_RTI;
            ST_RTI:   if (period_end) state_next = ST_RESP;
            ST_RESP:  if (host.rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Registered strobes, TDI, IR drive, bit counter and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            strb        <= '0;
            tdi_q       <= 1'b0;
            ir_in_q     <= '0;
            bit_cnt     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dr_q    <= '0;
            rsp_ir_q    <= '0;
        end else begin
            strb        <= strobe_of(state_next);
            rsp_valid_q <= (state_next == ST_RESP);
            if (accept) begin
                ir_in_q <= host.cmd_ir;
                bit_cnt <= '0;
            end
            if (period_end) begin
                if (state == ST_UIR) begin
                    rsp_ir_q <= vji_ir_out;
                end
                if (state == ST_SHIFT) begin
                    if (last_bit) begin
                        rsp_dr_q <= shift_in;
                    end else begin
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end
                // TDI presents the LSB the shift register will hold next period
                if (state_next == ST_SHIFT) begin
                    tdi_q <= (state == ST_SHIFT) ? sr[1] : sr[0];
                end else begin
                    tdi_q <= 1'b0;
                end
            end
        end
    end

    // DR shift register: loaded on accept, shifts right with TDO in at MSB
    always_ff @(posedge clk) begin
        if (accept) begin
            sr <= host.cmd_dr;
        end else if (period_end && (state == ST_SHIFT)) begin
            sr <= shift_in;
        end
    end

    assign vji_uir        = strb[4];
    assign vji_cdr        = strb[3];
    assign vji_sdr        = strb[2];
    assign vji_udr        = strb[1];
    assign vji_rti        = strb[0];
    assign vji_tdi        = tdi_q;
    assign vji_ir_in      = ir_in_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_dr    = rsp_dr_q;
    assign host.rsp_ir    = rsp_ir_q;

endmodule

// File: tb/tb_mp3_pc_debug_jtag_host.sv
// Directed bench for mp3_pc_debug_jtag_host with a TCK-driven loopback
// shift model on vji_tdo and an IR readback source active during UIR.
module tb_mp3_pc_debug_jtag_host;

    localparam int DRW = 38;
    localparam int TXN = 168;   // (38 + 4) periods * 4 clk

    localparam logic [DRW-1:0] VA = 38'h2A_5A5A_A5A5;
    localparam logic [DRW-1:0] VB = 38'h15_0F0F_F0F0;
    localparam logic [DRW-1:0] VC = 38'h0C_DEAD_BEEF;
    localparam logic [DRW-1:0] VD = 38'h33_3333_3333;
    localparam logic [DRW-1:0] VE = 38'h12_3456_789A;
    localparam logic [DRW-1:0] VG = 38'h3F_FFFF_FFFE;
    localparam logic [DRW-1:0] VH = 38'h00_0000_0001;

    logic       clk = 1'b0;
    logic       reset;
    logic       vji_tck, vji_tdi, vji_tdo;
    logic [1:0] vji_ir_in, vji_ir_out, ir_out_val;
    logic       vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    logic [DRW-1:0] model, model_init;
    logic           model_load = 1'b0;
    logic           tck_d = 1'b0;
    logic           tdo_r = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mp3_pc_debug_jtag_host_if #(.DR_WIDTH(DRW), .IR_WIDTH(2)) host ();

    mp3_pc_debug_jtag_host dut (
        .clk        (clk),
        .reset      (reset),
        .host       (host.slave),
        .vji_tck    (vji_tck),
        .vji_tdi    (vji_tdi),
        .vji_ir_in  (vji_ir_in),
        .vji_uir    (vji_uir),
        .vji_cdr    (vji_cdr),
        .vji_sdr    (vji_sdr),
        .vji_udr    (vji_udr),
        .vji_rti    (vji_rti),
        .vji_tdo    (vji_tdo),
        .vji_ir_out (vji_ir_out)
    );

    assign vji_ir_out = vji_uir ? ir_out_val : 2'b00;
    assign vji_tdo    = tdo_r;

    // Slave-side DR model: on each TCK rise during SDR, present the current
    // LSB on TDO and shift TDI in at the MSB.
    always @(posedge clk) begin
        tck_d <= vji_tck;
        if (model_load) begin
            model <= model_init;
            tdo_r <= 1'b0;
        end else if (vji_tck && !tck_d && vji_sdr) begin
            tdo_r <= model[0];
            model <= {vji_tdi, model[DRW-1:1]};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_model(input logic [DRW-1:0] v);
        model_init = v;
        model_load = 1'b1;
        step();
        model_load = 1'b0;
    endtask

    // Present a command while idle; returns just after the accepting edge
    task automatic issue(input logic [1:0] ir, input logic [DRW-1:0] dr);
        host.cmd_ir    = ir;
        host.cmd_dr    = dr;
        host.cmd_valid = 1'b1;
        chk("cmd_ready_idle", 64'(host.cmd_ready), 64'd1);
        step();
        host.cmd_valid = 1'b0;
    endtask

    // Walk one transaction from just after its accepting edge to RESP
    task automatic run_txn(input string nm, input logic [1:0] ir, input logic [DRW-1:0] dr,
                           input logic [DRW-1:0] exp_rsp, input logic [1:0] exp_ir);
        int seq_err = 0;
        int tck_err = 0;
        int ir_err  = 0;
        int tdi_err = 0;
        int early   = 0;
        logic [4:0] s, es;
        logic       et;
        for (int k = 0; k < TXN; k++) begin
            s  = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
            es = (k < 4)   ? 5'b10000 :
                 (k < 8)   ? 5'b01000 :
                 (k < 160) ? 5'b00100 :
                 (k < 164) ? 5'b00010 : 5'b00001;
            et = ((k % 4) >= 2);
            if (s !== es) seq_err++;
            if (vji_tck !== et) tck_err++;
            if (vji_ir_in !== ir) ir_err++;
            if (k >= 8 && k < 160 && vji_tdi !== dr[(k - 8) / 4]) tdi_err++;
            if (host.rsp_valid !== 1'b0 || host.cmd_ready !== 1'b0) early++;
            step();
        end
        chk($sformatf("%s_strobe_seq_errs", nm), 64'(seq_err), 64'd0);
        chk($sformatf("%s_tck_errs", nm), 64'(tck_err), 64'd0);
        chk($sformatf("%s_ir_in_errs", nm), 64'(ir_err), 64'd0);
        chk($sformatf("%s_tdi_errs", nm), 64'(tdi_err), 64'd0);
        chk($sformatf("%s_early_rsp_errs", nm), 64'(early), 64'd0);
        chk($sformatf("%s_rsp_valid_at_168", nm), 64'(host.rsp_valid), 64'd1);
        chk($sformatf("%s_rsp_dr", nm), 64'(host.rsp_dr), 64'(exp_rsp));
        chk($sformatf("%s_rsp_ir", nm), 64'(host.rsp_ir), 64'(exp_ir));
        chk($sformatf("%s_model_end", nm), 64'(model), 64'(dr));
        chk($sformatf("%s_strobes_in_resp", nm),
            64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
        chk($sformatf("%s_tck_in_resp", nm), 64'(vji_tck), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp_err;
        int udr_seen;
        int rsp_seen;

        reset          = 1'b1;
        host.cmd_valid = 1'b0;
        host.cmd_ir    = 2'd0;
        host.cmd_dr    = '0;
        host.rsp_ready = 1'b0;
        ir_out_val     = 2'b00;
        model_init     = '0;

        // Reset
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
        chk("rst_tck", 64'(vji_tck), 64'd0);
        chk("rst_tdi", 64'(vji_tdi), 64'd0);
        chk("rst_ir_in", 64'(vji_ir_in), 64'd0);
        chk("rst_cmd_ready", 64'(host.cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(host.rsp_valid), 64'd0);
        chk("rst_rsp_dr", 64'(host.rsp_dr), 64'd0);
        chk("rst_rsp_ir", 64'(host.rsp_ir), 64'd0);

        // Loopback, strobe order, IR readback
        load_model(VA);
        ir_out_val = 2'b11;
        issue(2'd2, VB);
        run_txn("t1", 2'd2, VB, VA, 2'b11);

        // Response backpressure with a second command waiting
        host.cmd_ir    = 2'd1;
        host.cmd_dr    = VC;
        host.cmd_valid = 1'b1;
        ir_out_val     = 2'b01;
        bp_err         = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (host.rsp_valid !== 1'b1 || host.rsp_dr !== VA || host.rsp_ir !== 2'b11 ||
                host.cmd_ready !== 1'b0 || vji_uir !== 1'b0) bp_err++;
        end
        chk("bp_stable_errs", 64'(bp_err), 64'd0);
        host.rsp_ready = 1'b1;
        step();
        host.rsp_ready = 1'b0;
        chk("bp_rsp_valid_after_hs", 64'(host.rsp_valid), 64'd0);
        chk("bp_cmd_ready_after_hs", 64'(host.cmd_ready), 64'd1);
        step();
        host.cmd_valid = 1'b0;
        chk("bp_accept_next_edge_uir", 64'(vji_uir), 64'd1);
        chk("bp_accept_next_edge_ready", 64'(host.cmd_ready), 64'd0);
        run_txn("t2", 2'd1, VC, VB, 2'b01);
        host.rsp_ready = 1'b1;
        step();
        host.rsp_ready = 1'b0;
        chk("t2_rsp_valid_drop", 64'(host.rsp_valid), 64'd0);

        // Abort at SHIFT bit 17 (periods 2+17, clk 76..79 after accept)
        load_model(VE);
        issue(2'd0, VD);
        repeat (77) step();
        chk("abort_in_shift", 64'(vji_sdr), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
        chk("abort_tck", 64'(vji_tck), 64'd0);
        chk("abort_tdi", 64'(vji_tdi), 64'd0);
        chk("abort_ir_in", 64'(vji_ir_in), 64'd0);
        chk("abort_rsp_valid", 64'(host.rsp_valid), 64'd0);
        chk("abort_rsp_dr", 64'(host.rsp_dr), 64'd0);
        chk("abort_cmd_ready", 64'(host.cmd_ready), 64'd1);
        udr_seen = 0;
        rsp_seen = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (vji_udr !== 1'b0) udr_seen++;
            if (host.rsp_valid !== 1'b0) rsp_seen++;
        end
        chk("abort_no_udr", 64'(udr_seen), 64'd0);
        chk("abort_no_rsp", 64'(rsp_seen), 64'd0);

        // Fresh command after abort
        load_model(VG);
        ir_out_val = 2'b10;
        issue(2'd3, VH);
        run_txn("t4", 2'd3, VH, VG, 2'b10);
        host.rsp_ready = 1'b1;
        step();
        host.rsp_ready = 1'b0;
        chk("t4_idle_ready", 64'(host.cmd_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
